// File: rtl/mult_pkg.sv
// Shared types and widths for the Booth multiplier MAC sequencer.
// Build option: SAT_EN selects a saturating accumulate.
package mult_pkg;

  localparam int OP_W            = 8;
  localparam int PROD_W          = 16;
  localparam int DEF_MUL_LATENCY = 11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ACC,
    OUT
  } state_t;

endpackage

// File: rtl/mult_mac_seq_if.sv
// Operand-pair input stream and frame-sum output stream.
// Build option: none (SAT_EN only affects mac_acc_unit).
interface mult_mac_seq_if
  import mult_pkg::*;
#(
  parameter int ACC_W = 24
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [OP_W-1:0]  in_a;
  logic signed [OP_W-1:0]  in_b;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc
  );

endinterface

// File: rtl/mac_acc_unit.sv
// Signed frame accumulator for 16-bit products.
// Build option: SAT_EN clamps at the ACC_W limits, otherwise wraps.
module mac_acc_unit
  import mult_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [ACC_W-1:0] nxt;

`ifdef SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum;

  // one guard bit exposes overflow in either direction
  always_comb begin
    sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    nxt = sum[ACC_W-1:0];
    unique case (1'b1)
      (sum[ACC_W] & ~sum[ACC_W-1]): nxt = MIN_V;
      (~sum[ACC_W] & sum[ACC_W-1]): nxt = MAX_V;
      default:                      nxt = sum[ACC_W-1:0];
    endcase
  end
`else
  always_comb begin
    nxt = acc + ACC_W'(prod);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= nxt;
    end
  end

endmodule

// File: rtl/mult_mac_seq.sv
// Operand sequencer and frame accumulator around the Booth multiplier.
// Build option: SAT_EN (saturating accumulate, see mac_acc_unit).
module mult_mac_seq
  import mult_pkg::*;
#(
  parameter int ACC_W       = 24,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  mult_mac_seq_if.slave            io,
  output logic                     mul_start,
  output logic signed [OP_W-1:0]   mul_a,
  output logic signed [OP_W-1:0]   mul_b,
  input  logic                     mul_done,
  input  logic signed [PROD_W-1:0] mul_product,
  output logic                     err
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MUL_LATENCY);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     last_q;
  logic signed [PROD_W-1:0] prod_q;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_en;
  logic                     acc_clr;

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid;
  assign io.out_acc   = acc;

  assign acc_en  = (state == ACC);
  assign acc_clr = (state == OUT) && io.out_ready;

  mac_acc_unit #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .en   (acc_en),
    .prod (prod_q),
    .acc  (acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_q    <= 1'b0;
      prod_q    <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            mul_a     <= io.in_a;
            mul_b     <= io.in_b;
            last_q    <= io.in_last;
            mul_start <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // done is sticky, so a low level here means a dead multiplier
          if (cnt == CNT_END) begin
            prod_q    <= mul_product;
            mul_start <= 1'b0;
            cnt       <= '0;
            if (!mul_done) err <= 1'b1;
            state     <= ACC;
          end
        end
        ACC: begin
          out_valid <= last_q;
          state     <= last_q ? OUT : IDLE;
        end
        OUT: begin
          if (io.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_mac_seq.sv
// Randomized self-checking bench for mult_mac_seq with a
// behavioural Booth multiplier stand-in on the mul_* side.
module tb_mult_mac_seq;

  localparam int ACC_W = 16;
  localparam int ML    = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic               mul_start;
  logic signed [7:0]  mul_a;
  logic signed [7:0]  mul_b;
  logic               mul_done;
  logic signed [15:0] mul_product;
  logic               err;

  int n_tests = 0;
  int n_fail  = 0;

  int qa[$];
  int qb[$];

  mult_mac_seq_if #(.ACC_W(ACC_W)) io ();

  mult_mac_seq #(
    .ACC_W       (ACC_W),
    .MUL_LATENCY (ML)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (io),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .err         (err)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: restarts on a rising start level,
  // publishes a*b and a sticky done after a few cycles
  logic               mdl_prev  = 1'b0;
  int                 mdl_cnt   = 0;
  logic               mdl_done  = 1'b0;
  logic signed [15:0] mdl_prod  = '0;
  logic               stub_dead = 1'b0;

  always @(posedge clk) begin
    mdl_prev <= mul_start;
    if (mul_start && !mdl_prev) begin
      mdl_cnt  <= 1;
      mdl_done <= 1'b0;
    end else if (mul_start && mdl_cnt < 8) begin
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_cnt == 7) begin
        mdl_done <= 1'b1;
        mdl_prod <= 16'(mul_a) * 16'(mul_b);
      end
    end
  end

  assign mul_done    = mdl_done & ~stub_dead;
  assign mul_product = mdl_prod;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_acc(input longint acc,
                                     input longint p);
    longint s;
    longint lim;
    logic signed [ACC_W-1:0] w;
    s   = acc + p;
    lim = longint'(1) << (ACC_W - 1);
`ifdef SAT_EN
    if (s > lim - 1) return lim - 1;
    if (s < -lim) return -lim;
    return s;
`else
    w = s[ACC_W-1:0];
    return longint'(w);
`endif
  endfunction

  task automatic send_pair(input int a, input int b,
                           input bit last);
    int k;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_a     = 8'(a);
    io.in_b     = 8'(b);
    io.in_last  = last;
    k = 0;
    while (!io.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input longint exp);
    int k;
    @(negedge clk);
    k = 0;
    while (!io.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check({tag, "_timeout"}, 0, 1);
    else check(tag, longint'(io.out_acc), exp);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    longint acc;
    acc = 0;
    foreach (qa[i]) begin
      send_pair(qa[i], qb[i], i == qa.size() - 1);
      acc = ref_acc(acc, longint'(qa[i] * qb[i]));
    end
    get_result(tag, acc);
  endtask

  initial begin
    int busy;
    int st;
    int bad;
    int k;
    longint hold;
    longint exp;

    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", io.in_ready, 1);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_out_acc", io.out_acc, 0);
    check("rst_err", err, 0);
    rst = 1'b1;

    // single pair plus result latency
    send_pair(3, 4, 1'b1);
    k = 0;
    @(negedge clk);
    while (!io.out_valid && k < 100) begin
      k++;
      @(negedge clk);
    end
    check("result_latency", k, ML + 1);
    get_result("single_3x4", 12);
    @(negedge clk);
    check("out_valid_drop", io.out_valid, 0);
    check("err_clean", err, 0);

    qa = '{-5, 2};
    qb = '{7, 3};
    run_frame("frame_m29");
    qa = '{1};
    qb = '{1};
    run_frame("frame_cleared");

    // in_valid held high across a whole run
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_a     = 8'(6);
    io.in_b     = 8'(-7);
    io.in_last  = 1'b0;
    @(posedge clk);
    #1;
    io.in_a    = 8'(-3);
    io.in_b    = 8'(5);
    io.in_last = 1'b1;
    busy = 0;
    st   = 0;
    @(negedge clk);
    while (!io.in_ready && busy < 100) begin
      busy++;
      if (mul_start) st++;
      @(negedge clk);
    end
    check("busy_cycles", busy, ML + 1);
    check("start_cycles", st, ML);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    get_result("held_valid", ref_acc(-42, -15));

    // output backpressure with a pending pair
    send_pair(10, -11, 1'b1);
    k = 0;
    @(negedge clk);
    while (!io.out_valid && k < 100) begin
      k++;
      @(negedge clk);
    end
    check("bp_out_valid", io.out_valid, 1);
    hold = longint'(io.out_acc);
    check("bp_value", hold, -110);
    io.in_valid = 1'b1;
    io.in_a     = 8'(-9);
    io.in_b     = 8'(-9);
    io.in_last  = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!io.out_valid || io.in_ready ||
          longint'(io.out_acc) != hold) bad++;
    end
    check("bp_hold", bad, 0);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    send_pair(-9, -9, 1'b1);
    get_result("bp_release", 81);

    // randomized frames
    for (int f = 0; f < 15; f++) begin
      int n;
      n = $urandom_range(1, 4);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(int'($urandom_range(0, 255)) - 128);
        qb.push_back(int'($urandom_range(0, 255)) - 128);
      end
      run_frame($sformatf("rand_%0d", f));
    end

    // accumulator limits
    qa = '{127, 127, 127};
    qb = '{127, 127, 127};
    run_frame("limit_pos");
    qa = '{-128, -128, -128};
    qb = '{127, 127, 127};
    run_frame("limit_neg");

    // dead multiplier sets the sticky error
    stub_dead = 1'b1;
    send_pair(1, 1, 1'b0);
    repeat (ML + 3) @(negedge clk);
    check("err_set", err, 1);
    stub_dead = 1'b0;

    // reset in the middle of a run
    send_pair(9, 9, 1'b0);
    repeat (5) @(negedge clk);
    check("mid_run_start", mul_start, 1);
    rst = 1'b0;
    #1;
    check("rr_mul_start", mul_start, 0);
    check("rr_in_ready", io.in_ready, 1);
    check("rr_out_valid", io.out_valid, 0);
    check("rr_err", err, 0);
    check("rr_mul_a", mul_a, 0);
    check("rr_out_acc", io.out_acc, 0);
    @(negedge clk);
    rst = 1'b1;
    exp = ref_acc(0, -6);
    qa = '{2};
    qb = '{-3};
    run_frame("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
